// File: rtl/sap1_datapath.sv
`default_nettype none
// ============================================================================
// Module   : sap1_datapath
// Purpose  : SAP-1 datapath (PC, MAR, RAM, IR, A, B, ALU, OUT, shared W bus)
//            executing one control word per clock from the control unit.
// Revision : 1.0  initial release
// ============================================================================
module sap1_datapath #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int OPC_W  = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              Cp,
    input  logic              Ep,
    input  logic              Ej,
    input  logic              Eu,
    input  logic              Add,
    input  logic              Sub,
    input  logic              AndOp,
    input  logic              OrOp,
    input  logic              XorOp,
    input  logic              NotOp,
    input  logic              La,
    input  logic              Ea,
    input  logic              Lb,
    input  logic              Lm,
    input  logic              CE,
    input  logic              L1,
    input  logic              Ei,
    input  logic              L0,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [OPC_W-1:0]  opcode,
    output logic [DATA_W-1:0] out_reg,
    output logic [DATA_W-1:0] w_bus,
    output logic [ADDR_W-1:0] pc,
    output logic              flag_c,
    output logic              flag_z,
    output logic              bus_err,
    output logic              alu_err
);

    localparam int c_DEPTH = 2 ** ADDR_W;
    localparam int c_PAD_W = DATA_W - ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              flag_c_q, flag_c_d;
    logic              flag_z_q, flag_z_d;
    logic              bus_err_q, bus_err_d;
    logic              alu_err_q, alu_err_d;

    logic [DATA_W-1:0] ram_q [c_DEPTH];

    logic [DATA_W-1:0] w_ram_rd;
    logic [DATA_W-1:0] w_pc_ext;
    logic [DATA_W-1:0] w_opnd_ext;
    logic [2:0]        w_drv_cnt;
    logic              w_bus_conflict;
    logic [DATA_W-1:0] w_bus_val;

    logic [2:0]        w_sel_cnt;
    logic              w_alu_valid;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;

    // RAM read is asynchronous, so a same-cycle write is seen only after the edge
    assign w_ram_rd   = ram_q[mar_q];
    assign w_pc_ext   = {{c_PAD_W{1'b0}}, pc_q};
    assign w_opnd_ext = {{c_PAD_W{1'b0}}, ir_q[ADDR_W-1:0]};

    assign w_drv_cnt = {2'b00, Ep} + {2'b00, CE} + {2'b00, Ei}
                     + {2'b00, Ea} + {2'b00, Eu};
    assign w_bus_conflict = (w_drv_cnt > 3'd1);

    always_comb begin
        w_bus_val = '0;
        if (w_drv_cnt == 3'd1) begin
            w_bus_val = ({DATA_W{Ep}} & w_pc_ext)
                      | ({DATA_W{CE}} & w_ram_rd)
                      | ({DATA_W{Ei}} & w_opnd_ext)
                      | ({DATA_W{Ea}} & a_q)
                      | ({DATA_W{Eu}} & w_alu_res);
        end
    end

    assign w_sel_cnt = {2'b00, Add} + {2'b00, Sub} + {2'b00, AndOp}
                     + {2'b00, OrOp} + {2'b00, XorOp} + {2'b00, NotOp};
    assign w_alu_valid = (w_sel_cnt == 3'd1);

    assign w_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign w_diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        if (w_alu_valid) begin
            if (Add) begin
                w_alu_res = w_sum[DATA_W-1:0];
                w_alu_c   = w_sum[DATA_W];
            end else if (Sub) begin
                w_alu_res = w_diff[DATA_W-1:0];
                w_alu_c   = ~w_diff[DATA_W];
            end else if (AndOp) begin
                w_alu_res = a_q & b_q;
            end else if (OrOp) begin
                w_alu_res = a_q | b_q;
            end else if (XorOp) begin
                w_alu_res = a_q ^ b_q;
            end else begin
                w_alu_res = ~a_q;
            end
        end
    end

    always_comb begin
        pc_d      = pc_q;
        mar_d     = mar_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        out_d     = out_q;
        flag_c_d  = flag_c_q;
        flag_z_d  = flag_z_q;
        bus_err_d = bus_err_q;
        alu_err_d = alu_err_q;
        if (CLR) begin
            pc_d      = '0;
            mar_d     = '0;
            ir_d      = '0;
            a_d       = '0;
            b_d       = '0;
            out_d     = '0;
            flag_c_d  = 1'b0;
            flag_z_d  = 1'b0;
            bus_err_d = 1'b0;
            alu_err_d = 1'b0;
        end else begin
            // A jump wins over a simultaneous increment
            if (Ej) begin
                pc_d = w_bus_val[ADDR_W-1:0];
            end else if (Cp) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (Lm) mar_d = w_bus_val[ADDR_W-1:0];
            if (L1) ir_d  = w_bus_val;
            if (La) a_d   = w_bus_val;
            if (Lb) b_d   = w_bus_val;
            if (L0) out_d = w_bus_val;
            if (La && Eu) begin
                flag_c_d = w_alu_c;
                flag_z_d = (w_bus_val == '0);
            end
            bus_err_d = bus_err_q | w_bus_conflict;
            alu_err_d = alu_err_q | (Eu & ~w_alu_valid);
        end
    end

    always_ff @(posedge CLK) begin
        pc_q      <= pc_d;
        mar_q     <= mar_d;
        ir_q      <= ir_d;
        a_q       <= a_d;
        b_q       <= b_d;
        out_q     <= out_d;
        flag_c_q  <= flag_c_d;
        flag_z_q  <= flag_z_d;
        bus_err_q <= bus_err_d;
        alu_err_q <= alu_err_d;
    end

    // Program load port stays live during CLR so code can be loaded in reset
    always_ff @(posedge CLK) begin
        if (prog_we) begin
            ram_q[prog_addr] <= prog_data;
        end
    end

    assign opcode  = ir_q[DATA_W-1 -: OPC_W];
    assign out_reg = out_q;
    assign w_bus   = w_bus_val;
    assign pc      = pc_q;
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;
    assign bus_err = bus_err_q;
    assign alu_err = alu_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sap1_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap1_datapath
// Purpose  : Directed self-checking bench for sap1_datapath.
// Revision : 1.0  initial release
// ============================================================================
module tb_sap1_datapath;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       Cp, Ep, Ej, Eu;
    logic       Add, Sub, AndOp, OrOp, XorOp, NotOp;
    logic       La, Ea, Lb, Lm, CE, L1, Ei, L0;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] opcode;
    logic [7:0] out_reg;
    logic [7:0] w_bus;
    logic [3:0] pc;
    logic       flag_c, flag_z, bus_err, alu_err;

    int total = 0;
    int bad   = 0;

    sap1_datapath #(.ADDR_W(4), .DATA_W(8), .OPC_W(4)) dut (
        .CLK(CLK), .CLR(CLR), .Cp(Cp), .Ep(Ep), .Ej(Ej), .Eu(Eu),
        .Add(Add), .Sub(Sub), .AndOp(AndOp), .OrOp(OrOp), .XorOp(XorOp), .NotOp(NotOp),
        .La(La), .Ea(Ea), .Lb(Lb), .Lm(Lm), .CE(CE), .L1(L1), .Ei(Ei), .L0(L0),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .out_reg(out_reg), .w_bus(w_bus), .pc(pc),
        .flag_c(flag_c), .flag_z(flag_z), .bus_err(bus_err), .alu_err(alu_err)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic idle();
        {Cp, Ep, Ej, Eu, Add, Sub, AndOp, OrOp, XorOp, NotOp} = '0;
        {La, Ea, Lb, Lm, CE, L1, Ei, L0} = '0;
        prog_we = 1'b0;
    endtask

    // Apply the current control word across one rising edge, then go idle
    task automatic tick();
        @(posedge CLK);
        #1;
        idle();
        #1;
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
    endtask

    initial begin
        CLR = 1'b1; prog_addr = '0; prog_data = '0;
        idle();
        @(posedge CLK); #1;
        prog(4'h0, 8'h4E);
        prog(4'h1, 8'h0F);
        prog(4'h2, 8'h05);
        prog(4'h3, 8'h03);
        prog(4'h5, 8'hA7);
        prog(4'hE, 8'h20);
        CLR = 1'b0;

        check_val("rst_pc", 16'(pc), 16'h0);
        check_val("rst_out", 16'(out_reg), 16'h0);
        check_val("rst_opc", 16'(opcode), 16'h0);
        check_val("rst_flags", 16'({flag_c, flag_z, bus_err, alu_err}), 16'h0);
        check_val("rst_bus", 16'(w_bus), 16'h0);

        // Fetch
        Ep = 1; Lm = 1; #1; check_val("t0_bus", 16'(w_bus), 16'h00); tick();
        CE = 1; L1 = 1; #1; check_val("t1_bus", 16'(w_bus), 16'h4E); tick();
        check_val("fetch_opc", 16'(opcode), 16'h4);
        Cp = 1; tick();
        check_val("fetch_pc", 16'(pc), 16'h1);

        // NOT: A=0F -> F0
        Ep = 1; Lm = 1; tick();
        CE = 1; La = 1; #1; check_val("lda_bus", 16'(w_bus), 16'h0F); tick();
        Eu = 1; NotOp = 1; La = 1; #1; check_val("not_bus", 16'(w_bus), 16'hF0); tick();
        check_val("not_flags", 16'({flag_c, flag_z}), 16'h0);
        Ea = 1; #1; check_val("not_a", 16'(w_bus), 16'hF0); idle();

        // ADD: F0 + RAM[E]=20
        Ei = 1; Lm = 1; #1; check_val("t3_bus", 16'(w_bus), 16'h0E); tick();
        CE = 1; Lb = 1; #1; check_val("t4_bus", 16'(w_bus), 16'h20); tick();
        Eu = 1; Add = 1; La = 1; #1; check_val("add_bus", 16'(w_bus), 16'h10); tick();
        check_val("add_c", 16'(flag_c), 16'h1);
        check_val("add_z", 16'(flag_z), 16'h0);
        Ea = 1; L0 = 1; tick();
        check_val("add_out", 16'(out_reg), 16'h10);

        // SUB 5-5
        Cp = 1; tick();
        check_val("pc2", 16'(pc), 16'h2);
        Ep = 1; Lm = 1; tick();
        CE = 1; La = 1; tick();
        CE = 1; Lb = 1; tick();
        Eu = 1; Sub = 1; La = 1; tick();
        check_val("sub_eq_flags", 16'({flag_c, flag_z}), 16'h3);
        Ea = 1; #1; check_val("sub_eq_a", 16'(w_bus), 16'h00); idle();

        // SUB 3-5
        Cp = 1; tick();
        Ep = 1; Lm = 1; tick();
        CE = 1; La = 1; tick();
        Eu = 1; Sub = 1; La = 1; tick();
        check_val("sub_lt_flags", 16'({flag_c, flag_z}), 16'h0);
        Ea = 1; #1; check_val("sub_lt_a", 16'(w_bus), 16'hFE); idle();

        // Lb&Eu uses old B: FE+05 -> B=03; flags hold
        Eu = 1; Add = 1; Lb = 1; tick();
        check_val("lbeu_flags", 16'({flag_c, flag_z}), 16'h0);
        Eu = 1; Sub = 1;   #1; check_val("lbeu_b", 16'(w_bus), 16'hFB); idle();
        Eu = 1; AndOp = 1; #1; check_val("and", 16'(w_bus), 16'h02); idle();
        Eu = 1; OrOp = 1;  #1; check_val("or", 16'(w_bus), 16'hFF); idle();
        Eu = 1; XorOp = 1; #1; check_val("xor", 16'(w_bus), 16'hFD); idle();
        #1;

        // Jump with Ej beating Cp, then wrap
        Cp = 1; tick();
        Cp = 1; tick();
        check_val("pc5", 16'(pc), 16'h5);
        Ep = 1; Lm = 1; tick();
        CE = 1; L1 = 1; tick();
        check_val("jmp_opc", 16'(opcode), 16'hA);
        Ei = 1; Ej = 1; Cp = 1; tick();
        check_val("jmp_pc", 16'(pc), 16'h7);
        Ea = 1; Ej = 1; tick();
        check_val("jmp_a_pc", 16'(pc), 16'hE);
        Cp = 1; tick();
        check_val("pc15", 16'(pc), 16'hF);
        Cp = 1; tick();
        check_val("pc_wrap", 16'(pc), 16'h0);

        // Bus conflict and ALU error
        Ep = 1; Ea = 1; #1;
        check_val("conf_bus", 16'(w_bus), 16'h00);
        check_val("conf_pre", 16'(bus_err), 16'h0);
        tick();
        check_val("conf_set", 16'(bus_err), 16'h1);
        tick();
        check_val("conf_hold", 16'(bus_err), 16'h1);
        Eu = 1; Add = 1; Sub = 1; #1;
        check_val("aluerr_bus", 16'(w_bus), 16'h00);
        tick();
        check_val("aluerr_set", 16'(alu_err), 16'h1);
        Ea = 1; L0 = 1; tick();
        check_val("pre_rst_out", 16'(out_reg), 16'hFE);

        // Reset mid-T4 with a program write in the same cycle
        Ei = 1; Lm = 1; tick();
        CLR = 1; CE = 1; Lb = 1; prog_we = 1; prog_addr = 4'hE; prog_data = 8'h5A;
        tick();
        CLR = 0;
        check_val("clr_pc", 16'(pc), 16'h0);
        check_val("clr_out", 16'(out_reg), 16'h0);
        check_val("clr_opc", 16'(opcode), 16'h0);
        check_val("clr_flags", 16'({flag_c, flag_z, bus_err, alu_err}), 16'h0);
        Ea = 1; #1; check_val("clr_a", 16'(w_bus), 16'h00); idle();
        Eu = 1; Add = 1; #1; check_val("clr_b", 16'(w_bus), 16'h00); idle();
        CE = 1; #1; check_val("ram0_kept", 16'(w_bus), 16'h4E); idle();
        CE = 1; L1 = 1; tick();
        Ei = 1; Lm = 1; tick();
        CE = 1; #1; check_val("ram_prog", 16'(w_bus), 16'h5A); idle();

        // Same-cycle write/read returns old data
        CE = 1; prog_we = 1; prog_addr = 4'hE; prog_data = 8'h77; #1;
        check_val("ram_old", 16'(w_bus), 16'h5A);
        tick();
        CE = 1; #1; check_val("ram_new", 16'(w_bus), 16'h77); idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
